// File: rtl/mem_req_master.sv
// mem_req_master
//   Single-port requester for one rden/wren/acq slot of the memory controller.
//   Accepts a read/write command in IDLE and holds the request in REQ until the
//   controller acknowledges. It then issues a one-cycle response in RESP.
//   A wait counter bounds the REQ phase so a lost grant cannot hang the client.
//
//   Optional feature: define MEMREQ_RETRY_EN to reissue the request once after
//   the first timeout (one-cycle RETRY gap). An error is reported only on the
//   second timeout.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready          client command handshake (ready only in IDLE)
//   cmd_we/addr/wdata        command fields
//   rden, wren, Address, Din request to the controller (registered)
//   acq, Dq                  controller acknowledge and read data
//   rsp_valid/rdata/err      one-cycle response; rdata/err hold until next rsp
module mem_req_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rden,
    output logic              wren,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Din,
    input  logic              acq,
    input  logic [DATA_W-1:0] Dq,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int              CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RESP, RETRY} state_t;

    state_t          state;
    logic            we_q;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
`ifdef MEMREQ_RETRY_EN
    logic            retried;
`endif

    // Saturating increment: the counter never wraps back to zero.
    assign cnt_inc = (cnt == TMO) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            we_q      <= 1'b0;
            cnt       <= '0;
            rden      <= 1'b0;
            wren      <= 1'b0;
            Address   <= '0;
            Din       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef MEMREQ_RETRY_EN
            retried   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        Address   <= cmd_addr;
                        Din       <= cmd_wdata;
                        we_q      <= cmd_we;
                        rden      <= ~cmd_we;
                        wren      <= cmd_we;
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
`ifdef MEMREQ_RETRY_EN
                        retried   <= 1'b0;
`endif
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // acq is checked first so an acknowledge in the cycle the
                    // counter would reach TIMEOUT still counts as success.
                    if (acq) begin
                        rsp_rdata <= we_q ? '0 : Dq;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rden      <= 1'b0;
                        wren      <= 1'b0;
                        state     <= RESP;
                    end else if (cnt_inc == TMO) begin
                        cnt  <= cnt_inc;
                        rden <= 1'b0;
                        wren <= 1'b0;
`ifdef MEMREQ_RETRY_EN
                        if (!retried) begin
                            retried <= 1'b1;
                            state   <= RETRY;
                        end else begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
`else
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RESP: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                RETRY: begin
                    // Reissue the held address/data with a fresh wait budget.
                    cnt   <= '0;
                    rden  <= ~we_q;
                    wren  <= we_q;
                    state <= REQ;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    rden      <= 1'b0;
                    wren      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_master.sv
// Testbench for mem_req_master: directed cases plus randomized transactions,
// checked against a transaction-level model of request length, retry gap,
// response latency and response contents.
module tb_mem_req_master;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int T  = 15;
`ifdef MEMREQ_RETRY_EN
    localparam int LIM = 2 * T;
    localparam int RTY = 1;
`else
    localparam int LIM = T;
    localparam int RTY = 0;
`endif

    logic          clk = 1'b0, rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_we = 1'b0, acq = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0, Dq = '0;
    logic          cmd_ready, rden, wren, rsp_valid, rsp_err;
    logic [AW-1:0] Address;
    logic [DW-1:0] Din, rsp_rdata;

    mem_req_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rden(rden), .wren(wren), .Address(Address), .Din(Din),
        .acq(acq), .Dq(Dq),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int last_hi = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One command from IDLE to the following IDLE cycle. Entered and left at a
    // negedge with the DUT in IDLE. acq_at = REQ cycle (1-based, counted over
    // all request-high cycles) in which the controller acknowledges; values
    // outside 1..LIM mean never. stray: 0 none, 1 random, 2 always high acq
    // outside REQ. hold keeps cmd_valid asserted throughout.
    task automatic txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int acq_at, input logic [DW-1:0] dq, input int stray, input bit hold);
        int hi, lo, rsp_k, exp_hi, exp_lo;
        bit done, both, addr_bad, din_bad, dir_bad, exp_err;
        logic [DW-1:0] exp_rd;
        if (acq_at >= 1 && acq_at <= LIM) begin
            exp_err = 1'b0; exp_hi = acq_at; exp_lo = (acq_at > T) ? 1 : 0;
            exp_rd = we ? '0 : dq;
        end else begin
            exp_err = 1'b1; exp_hi = LIM; exp_lo = RTY; exp_rd = '0;
        end
        hi = 0; lo = 0; rsp_k = 0; done = 0;
        both = 0; addr_bad = 0; din_bad = 0; dir_bad = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = wd;
        chk("cmd_ready_idle", cmd_ready, 1);
        for (int k = 1; k <= 2 * T + 10 && !done; k++) begin
            @(negedge clk);
            cmd_valid = hold;
            cmd_we = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
            if (k == 1) chk("cmd_ready_busy", cmd_ready, 0);
            if (rden && wren) both = 1;
            if (rden || wren) begin
                hi++;
                if (hi == 1) chk("req_gap", ((cyc - last_hi) >= 3) ? 1 : 0, 1);
                last_hi = cyc;
                if (rden !== !we || wren !== we) dir_bad = 1;
                if (Address !== a) addr_bad = 1;
                if (we && Din !== wd) din_bad = 1;
            end else if (hi > 0 && !rsp_valid) lo++;
            if (rsp_valid) begin
                done = 1; rsp_k = k;
                chk("rsp_err", rsp_err, exp_err);
                chk("rsp_rdata", rsp_rdata, exp_rd);
            end
            if (rden || wren) begin
                acq = (hi == acq_at);
                Dq  = (hi == acq_at) ? dq : DW'($urandom);
            end else begin
                acq = (stray == 2) ? 1'b1 : (stray == 1) ? 1'($urandom) : 1'b0;
                Dq  = DW'($urandom);
            end
        end
        if (!done) begin
            chk("rsp_seen", 0, 1);
        end else begin
            chk("req_cycles", hi, exp_hi);
            chk("retry_gap", lo, exp_lo);
            chk("rsp_latency", rsp_k, exp_hi + exp_lo + 1);
            chk("rd_wr_both", both, 0);
            chk("req_dir", dir_bad, 0);
            chk("addr_stable", addr_bad, 0);
            chk("din_stable", din_bad, 0);
        end
        @(negedge clk);
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("ready_after_rsp", cmd_ready, 1);
        chk("req_low_after", {rden, wren}, 0);
        chk("rsp_err_hold", rsp_err, exp_err);
        chk("rsp_rdata_hold", rsp_rdata, exp_rd);
        acq = (stray == 2) ? 1'b1 : (stray == 1) ? 1'($urandom) : 1'b0;
    endtask

    // Abandon a read mid-request with a reset in its 2nd REQ cycle.
    task automatic rst_mid();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h3C3C; acq = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_pre_rden1", rden, 1);
        @(negedge clk);
        chk("rst_pre_rden2", rden, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_rden", rden, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        chk("rst_mid_rsp", rsp_valid, 0);
        chk("rst_mid_addr", Address, 0);
        @(negedge clk);
        chk("rst_after_rsp", rsp_valid, 0);
        chk("rst_after_rden", rden, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_req", {rden, wren}, 0);
        chk("rst_addr", Address, 0);
        chk("rst_din", Din, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        @(negedge clk);

        txn(1'b0, 16'hF00F, 16'h0000, 3, 16'hA55A, 0, 1'b0);
        txn(1'b1, 16'h0012, 16'hBEEF, 1, 16'h7777, 0, 1'b0);
        txn(1'b0, 16'h5555, 16'h0000, 0, 16'h0000, 0, 1'b0);
        txn(1'b0, 16'h00AA, 16'h0000, T, 16'h1234, 0, 1'b0);
        txn(1'b1, 16'h0BAD, 16'hCAFE, 0, 16'h0000, 1, 1'b0);
`ifdef MEMREQ_RETRY_EN
        txn(1'b0, 16'h0101, 16'h0000, T + 1, 16'h4321, 1, 1'b0);
        txn(1'b0, 16'h0202, 16'h0000, 2 * T, 16'h6789, 1, 1'b0);
`endif
        rst_mid();
        txn(1'b0, 16'h3C3C, 16'h0000, 2, 16'h0F0F, 0, 1'b0);

        // Back-to-back: client holds cmd_valid, controller holds acq high.
        for (int i = 0; i < 4; i++)
            txn(1'($urandom), AW'($urandom), DW'($urandom), 1, DW'($urandom), 2, 1'b1);
        cmd_valid = 1'b0; acq = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 30; i++)
            txn(1'($urandom), AW'($urandom), DW'($urandom),
                int'($urandom_range(0, LIM + 2)), DW'($urandom), 1, 1'($urandom));
        cmd_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
